// File: rtl/spm_pkg.sv
// Shared types and constants for the string processor / matcher.
// Contents: FSM state enum, hash/byte widths, default build parameters.
package spm_pkg;

    localparam int unsigned HASH_W          = 128;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned STR_LEN_DEF     = 19;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned MATCH_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } spm_state_e;

endpackage

// File: rtl/spm_match_fifo.sv
// Synchronous match FIFO with a look-ahead of the head entry.
// Ports:
//   clk, reset          clock, sync active-high reset
//   clr                 synchronous flush (batch restart)
//   push, wdata         write request / data (dropped when full unless popping)
//   pop                 read request (ignored when empty)
//   full, empty, count  registered occupancy status
//   head_load_c         head entry changes at the coming edge
//   head_next_c         head entry value after the coming edge (0 if empty)
module spm_match_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_load_c,
    output logic [WIDTH-1:0]           head_next_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next occupancy
    always_comb begin
        count_d = count;
        if (clr) begin
            count_d = '0;
        end else if (push_ok && !pop_ok) begin
            count_d = CW'(count + CW'(1));
        end else if (pop_ok && !push_ok) begin
            count_d = CW'(count - CW'(1));
        end
    end

    // Head look-ahead: what sits at the read pointer after this edge.
    always_comb begin
        head_load_c = 1'b0;
        head_next_c = mem[rd_ptr];
        if (clr) begin
            head_load_c = 1'b1;
            head_next_c = '0;
        end else if (pop_ok) begin
            head_load_c = 1'b1;
            if (count >= CW'(2)) begin
                head_next_c = mem[AW'(rd_ptr + AW'(1))];
            end else if (push_ok) begin
                head_next_c = wdata;
            end else begin
                head_next_c = '0;
            end
        end else if (empty && push_ok) begin
            head_load_c = 1'b1;
            head_next_c = wdata;
        end
    end

    // Pointers and status
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= AW'(wr_ptr + AW'(1));
            end
            if (pop_ok) begin
                rd_ptr <= AW'(rd_ptr + AW'(1));
            end
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/string_process_match_multi.sv
// Candidate-string generator and multi-match collector for the MD5 brute-force
// pipeline. Shifts the byte stream into STR_LEN-byte candidates for the MD5
// core, compares returned hashes with the target and queues up to MATCH_DEPTH
// matches, each read back char-by-char through a head shifter.
// Build option: SPM_HASH_MASK_EN adds proc_target_mask (sampled on proc_start)
// for masked / prefix hash compares; otherwise a full 128-bit compare is used.
// Ports:
//   clk, reset                   clock, sync active-high reset
//   proc_start, proc_num_bytes   batch start pulse, expected return count
//   proc_data, proc_data_valid   input byte stream
//   proc_target_hash             target {a,b,c,d}
//   proc_match_char_next/pop     head string shift / head entry discard
//   proc_done, proc_match, proc_match_count, proc_match_overflow,
//   proc_byte_pos, proc_match_char   batch status and head match readout
//   hash_ret, md5_msg_ret(_valid)    MD5 core return
//   md5_msg, md5_msg_valid           candidate to MD5 core
module string_process_match_multi
    import spm_pkg::*;
#(
    parameter int unsigned STR_LEN     = STR_LEN_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MATCH_DEPTH = MATCH_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             proc_start,
    input  logic [CNT_W-1:0]                 proc_num_bytes,
    input  logic [7:0]                       proc_data,
    input  logic                             proc_data_valid,
    input  logic [127:0]                     proc_target_hash,
`ifdef SPM_HASH_MASK_EN
    input  logic [127:0]                     proc_target_mask,
`endif
    input  logic                             proc_match_char_next,
    input  logic                             proc_match_pop,
    output logic                             proc_done,
    output logic                             proc_match,
    output logic [$clog2(MATCH_DEPTH+1)-1:0] proc_match_count,
    output logic                             proc_match_overflow,
    output logic [CNT_W-1:0]                 proc_byte_pos,
    output logic [7:0]                       proc_match_char,
    input  logic [127:0]                     hash_ret,
    input  logic [8*STR_LEN-1:0]             md5_msg_ret,
    input  logic                             md5_msg_ret_valid,
    output logic [8*STR_LEN-1:0]             md5_msg,
    output logic                             md5_msg_valid
);

    localparam int unsigned MSG_W = BYTE_W * STR_LEN;
    localparam int unsigned ENT_W = CNT_W + MSG_W;

    spm_state_e         state;
    spm_state_e         state_d;
    logic [CNT_W-1:0]   num_bytes;
    logic [CNT_W-1:0]   ret_count;
    logic [MSG_W-1:0]   head_str;
    logic               ret_accept;
    logic               is_match;
    logic               match_push;
    logic               pop_ok;
    logic               fifo_full;
    logic               fifo_empty;
    logic               head_load_c;
    logic [ENT_W-1:0]   head_next_c;

`ifdef SPM_HASH_MASK_EN
    logic [HASH_W-1:0]  mask_q;
    assign is_match = (((hash_ret ^ proc_target_hash) & mask_q) == '0);
`else
    assign is_match = (hash_ret == proc_target_hash);
`endif

    assign match_push = ret_accept && is_match;
    assign pop_ok     = proc_match_pop && !fifo_empty && !proc_start;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and return acceptance; proc_start overrides everything.
    always_comb begin
        state_d    = state;
        ret_accept = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_RUN: begin
                if (num_bytes == '0) begin
                    state_d = ST_DONE;
                end else if (md5_msg_ret_valid) begin
                    ret_accept = 1'b1;
                    if (CNT_W'(ret_count + CNT_W'(1)) == num_bytes) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase
        if (proc_start) begin
            state_d    = ST_RUN;
            ret_accept = 1'b0;
        end
    end

    // Batch bookkeeping, head shifter and candidate message path
    always_ff @(posedge clk) begin
        if (reset) begin
            proc_done           <= 1'b0;
            num_bytes           <= '0;
            ret_count           <= '0;
            proc_match_overflow <= 1'b0;
            proc_byte_pos       <= '0;
            head_str            <= '0;
            md5_msg             <= '0;
            md5_msg_valid       <= 1'b0;
`ifdef SPM_HASH_MASK_EN
            mask_q              <= '0;
`endif
        end else begin
            proc_done <= (state_d == ST_DONE);
            if (proc_start) begin
                num_bytes           <= proc_num_bytes;
                ret_count           <= '0;
                proc_match_overflow <= 1'b0;
`ifdef SPM_HASH_MASK_EN
                mask_q              <= proc_target_mask;
`endif
            end else begin
                if (ret_accept) begin
                    ret_count <= CNT_W'(ret_count + CNT_W'(1));
                end
                if (match_push && fifo_full && !pop_ok) begin
                    proc_match_overflow <= 1'b1;
                end
            end
            // A head change (push to empty, pop, flush) beats a char shift.
            if (head_load_c) begin
                {proc_byte_pos, head_str} <= head_next_c;
            end else if (proc_match_char_next && !fifo_empty) begin
                head_str <= {head_str[MSG_W-BYTE_W-1:0], BYTE_W'(0)};
            end
            if (proc_data_valid) begin
                md5_msg <= {md5_msg[MSG_W-BYTE_W-1:0], proc_data};
            end
            md5_msg_valid <= proc_data_valid;
        end
    end

    assign proc_match      = !fifo_empty;
    assign proc_match_char = head_str[MSG_W-1 -: BYTE_W];

    spm_match_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (MATCH_DEPTH)
    ) u_match_fifo (
        .clk         (clk),
        .reset       (reset),
        .clr         (proc_start),
        .push        (match_push),
        .wdata       ({ret_count, md5_msg_ret}),
        .pop         (pop_ok),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (proc_match_count),
        .head_load_c (head_load_c),
        .head_next_c (head_next_c)
    );

endmodule

// File: tb/tb_string_process_match_multi.sv
// Directed self-checking bench for string_process_match_multi (default params).
module tb_string_process_match_multi;

    localparam int unsigned STR_LEN = 19;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MSG_W   = 8 * STR_LEN;
    localparam int unsigned CW      = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             proc_start;
    logic [CNT_W-1:0] proc_num_bytes;
    logic [7:0]       proc_data;
    logic             proc_data_valid;
    logic [127:0]     proc_target_hash;
`ifdef SPM_HASH_MASK_EN
    logic [127:0]     proc_target_mask;
`endif
    logic             proc_match_char_next;
    logic             proc_match_pop;
    logic             proc_done;
    logic             proc_match;
    logic [CW-1:0]    proc_match_count;
    logic             proc_match_overflow;
    logic [CNT_W-1:0] proc_byte_pos;
    logic [7:0]       proc_match_char;
    logic [127:0]     hash_ret;
    logic [MSG_W-1:0] md5_msg_ret;
    logic             md5_msg_ret_valid;
    logic [MSG_W-1:0] md5_msg;
    logic             md5_msg_valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0]     tgt;
    logic [MSG_W-1:0] str_a;
    logic [MSG_W-1:0] str_e;
    logic [MSG_W-1:0] str_d;

    string_process_match_multi #(
        .STR_LEN     (STR_LEN),
        .CNT_W       (CNT_W),
        .MATCH_DEPTH (DEPTH)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .proc_start           (proc_start),
        .proc_num_bytes       (proc_num_bytes),
        .proc_data            (proc_data),
        .proc_data_valid      (proc_data_valid),
        .proc_target_hash     (proc_target_hash),
`ifdef SPM_HASH_MASK_EN
        .proc_target_mask     (proc_target_mask),
`endif
        .proc_match_char_next (proc_match_char_next),
        .proc_match_pop       (proc_match_pop),
        .proc_done            (proc_done),
        .proc_match           (proc_match),
        .proc_match_count     (proc_match_count),
        .proc_match_overflow  (proc_match_overflow),
        .proc_byte_pos        (proc_byte_pos),
        .proc_match_char      (proc_match_char),
        .hash_ret             (hash_ret),
        .md5_msg_ret          (md5_msg_ret),
        .md5_msg_ret_valid    (md5_msg_ret_valid),
        .md5_msg              (md5_msg),
        .md5_msg_valid        (md5_msg_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [CNT_W-1:0] n);
        proc_start     = 1'b1;
        proc_num_bytes = n;
        tick();
        proc_start     = 1'b0;
    endtask

    task automatic ret(input logic [MSG_W-1:0] msg, input logic [127:0] h);
        md5_msg_ret       = msg;
        hash_ret          = h;
        md5_msg_ret_valid = 1'b1;
        tick();
        md5_msg_ret_valid = 1'b0;
    endtask

    // Entry string whose first char is 'A'+i, rest zero
    function automatic logic [MSG_W-1:0] ent(input int i);
        return {8'(8'h41 + i), (MSG_W - 8)'(0)};
    endfunction

    task automatic status(input string tag, input logic [CW-1:0] cnt, input logic ovf,
                          input logic [CNT_W-1:0] pos, input logic [7:0] ch);
        chk({tag, ".count"}, 256'(proc_match_count), 256'(cnt));
        chk({tag, ".match"}, 256'(proc_match), 256'(cnt != '0));
        chk({tag, ".ovf"},   256'(proc_match_overflow), 256'(ovf));
        chk({tag, ".pos"},   256'(proc_byte_pos), 256'(pos));
        chk({tag, ".char"},  256'(proc_match_char), 256'(ch));
    endtask

    initial begin
        tgt   = 128'h0123456789abcdef_fedcba9876543210;
        str_a = "abcdefghijklmnopqrs";
        str_e = "efghijklmnopqrstuvw";
        str_d = "defghijklmnopqrstuv";
        reset = 1'b1;
        proc_start = 1'b0;
        proc_num_bytes = '0;
        proc_data = '0;
        proc_data_valid = 1'b0;
        proc_target_hash = tgt;
`ifdef SPM_HASH_MASK_EN
        proc_target_mask = '1;
`endif
        proc_match_char_next = 1'b0;
        proc_match_pop = 1'b0;
        hash_ret = '0;
        md5_msg_ret = '0;
        md5_msg_ret_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.done", 256'(proc_done), 256'(0));
        chk("rst.msg_valid", 256'(md5_msg_valid), 256'(0));
        chk("rst.msg", 256'(md5_msg), 256'(0));
        status("rst", '0, 1'b0, '0, 8'h00);
        reset = 1'b0;
        tick();

        // Message path: stream "a".."w"
        for (int i = 0; i < 23; i++) begin
            proc_data       = 8'(8'h61 + i);
            proc_data_valid = 1'b1;
            tick();
            chk("msg.valid", 256'(md5_msg_valid), 256'(1));
            if (i == 0)  chk("msg.first", 256'(md5_msg), 256'(8'h61));
            if (i == 18) chk("msg.a2s", 256'(md5_msg), 256'(str_a));
        end
        proc_data_valid = 1'b0;
        tick();
        chk("msg.idle_valid", 256'(md5_msg_valid), 256'(0));
        chk("msg.e2w", 256'(md5_msg), 256'(str_e));

        // Batch of 5, match at index 3, then walk the string
        start(16'd5);
        for (int i = 0; i < 5; i++) begin
            ret((i == 3) ? str_d : ent(i), (i == 3) ? tgt : (tgt ^ 128'h1));
            if (i == 3) chk("b5.done_early", 256'(proc_done), 256'(0));
        end
        chk("b5.done", 256'(proc_done), 256'(1));
        status("b5", CW'(1), 1'b0, 16'd3, 8'h64);
        ret(str_a, tgt);
        chk("b5.ignored_in_done", 256'(proc_match_count), 256'(1));
        for (int k = 1; k <= 19; k++) begin
            proc_match_char_next = 1'b1;
            tick();
            proc_match_char_next = 1'b0;
            chk("walk.char", 256'(proc_match_char), 256'((k < 19) ? 8'(8'h64 + k) : 8'h00));
        end
        proc_match_pop = 1'b1;
        tick();
        proc_match_pop = 1'b0;
        status("b5.pop", '0, 1'b0, '0, 8'h00);

        // Overflow: 6 matches into a 4-deep FIFO, then drain
        start(16'd10);
        for (int i = 0; i < 6; i++) ret(ent(i), tgt);
        status("ovf", CW'(4), 1'b1, 16'd0, 8'h41);
        chk("ovf.done", 256'(proc_done), 256'(0));
        for (int p = 1; p <= 4; p++) begin
            proc_match_pop = 1'b1;
            tick();
            proc_match_pop = 1'b0;
            if (p < 4) status("ovf.pop", CW'(4 - p), 1'b1, CNT_W'(p), 8'(8'h41 + p));
            else       status("ovf.pop_last", '0, 1'b1, '0, 8'h00);
        end
        proc_match_pop = 1'b1;
        tick();
        proc_match_pop = 1'b0;
        status("ovf.pop_empty", '0, 1'b1, '0, 8'h00);

        // Full FIFO: push and pop together, then pop beats char_next
        start(16'd10);
        for (int i = 0; i < 4; i++) ret(ent(i), tgt);
        status("full", CW'(4), 1'b0, 16'd0, 8'h41);
        proc_match_pop = 1'b1;
        ret(ent(4), tgt);
        proc_match_pop = 1'b0;
        status("full.pushpop", CW'(4), 1'b0, 16'd1, 8'h42);
        proc_match_pop = 1'b1;
        proc_match_char_next = 1'b1;
        tick();
        proc_match_pop = 1'b0;
        proc_match_char_next = 1'b0;
        status("full.pop_wins", CW'(3), 1'b0, 16'd2, 8'h43);
        proc_match_char_next = 1'b1;
        tick();
        proc_match_char_next = 1'b0;
        chk("full.shift", 256'(proc_match_char), 256'(8'h00));

        // Empty batch
        start(16'd0);
        chk("zero.done_1", 256'(proc_done), 256'(0));
        status("zero.cleared", '0, 1'b0, '0, 8'h00);
        tick();
        chk("zero.done_2", 256'(proc_done), 256'(1));
        ret(ent(0), tgt);
        chk("zero.ignored", 256'(proc_match_count), 256'(0));

        // Restart mid-RUN with a same-cycle matching return
        start(16'd10);
        ret(ent(0), tgt);
        ret(ent(1), tgt);
        chk("restart.pre", 256'(proc_match_count), 256'(2));
        proc_start     = 1'b1;
        proc_num_bytes = 16'd2;
        ret(ent(2), tgt);
        proc_start     = 1'b0;
        status("restart", '0, 1'b0, '0, 8'h00);
        chk("restart.done", 256'(proc_done), 256'(0));
        ret(ent(3), tgt ^ 128'h1);
        chk("restart.done_1", 256'(proc_done), 256'(0));
        ret(ent(4), tgt);
        chk("restart.done_2", 256'(proc_done), 256'(1));
        status("restart.match", CW'(1), 1'b0, 16'd1, 8'h45);

        // Reset mid-batch
        start(16'd10);
        ret(ent(0), tgt);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        status("midrst", '0, 1'b0, '0, 8'h00);
        chk("midrst.done", 256'(proc_done), 256'(0));

        // Prefix compare: hash differs from target only in the low bit
`ifdef SPM_HASH_MASK_EN
        proc_target_mask = {16'hFFFF, 112'h0};
`endif
        start(16'd1);
        ret(ent(7), tgt ^ 128'h1);
        chk("mask.done", 256'(proc_done), 256'(1));
`ifdef SPM_HASH_MASK_EN
        status("mask", CW'(1), 1'b0, 16'd0, 8'h48);
`else
        status("mask", '0, 1'b0, '0, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
